rr_queue_scheduler: RTL
=======================

Name: rr_queue_scheduler

Overview:
- Packet-granular round-robin scheduler that shares one egress datapath among QUEUE_COUNT queues.
- Each cycle it picks the next eligible queue circularly after the last-served queue, using find_next_valid-style search.
- It presents the selection downstream with a valid/ready handshake, then holds the grant until the packet-done pulse arrives.
- Sits between per-queue occupancy/enable logic and the dequeue/TX engine.

Parameters:
- QUEUE_COUNT, 8, number of queues arbitrated; must be ≥2.
- SEL_WIDTH, $clog2(QUEUE_COUNT), width of queue index.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- queue_req  input  QUEUE_COUNT  per-queue "has packet" flag, level
- queue_en  input  QUEUE_COUNT  per-queue enable (configuration); eligible = queue_req & queue_en
- m_sel  output  SEL_WIDTH  selected queue index
- m_sel_valid  output  1  m_sel valid
- m_sel_ready  input  1  downstream accepts selection
- pkt_done  input  1  one-cycle pulse: granted packet finished
- busy  output  1  grant held (packet in progress)
- last_sel  output  SEL_WIDTH  last-served queue index (round-robin pointer)

Behaviour:
- Reset values:
  - m_sel=0, m_sel_valid=0, busy=0.
  - last_sel=QUEUE_COUNT-1, so the first grant goes to the lowest eligible index.
  - FSM=IDLE.
  - Reset mid-operation aborts any grant with no further outputs.
- Search rule:
  - next = lowest eligible index strictly greater than last_sel; otherwise wrap to the lowest eligible index below last_sel.
  - If last_sel is the only eligible queue, it is re-selected; the search excludes it, so the scheduler handles this case explicitly.
- FSM states IDLE, OFFER, BUSY:
  - IDLE: if any eligible bit is set, register next into m_sel, set m_sel_valid=1, go to OFFER. Otherwise stay.
  - OFFER: m_sel and m_sel_valid stay stable until m_sel_ready=1; deasserting queue_req/queue_en does not withdraw or change the offer.
  - OFFER, on handshake (m_sel_valid & m_sel_ready):
    - last_sel<=m_sel, m_sel_valid<=0.
    - If pkt_done is high in the same cycle (single-beat packet), go to IDLE.
    - Otherwise busy<=1 and go to BUSY.
  - BUSY: on pkt_done, busy<=0 and go to IDLE.
  - pkt_done outside BUSY or the handshake cycle is ignored.
- Latency:
  - Eligible in IDLE at cycle N gives m_sel_valid at N+1.
  - After pkt_done, at least 1 IDLE cycle passes before the next m_sel_valid.
  - Back-to-back grants are therefore at best every 2 cycles plus the packet duration.
- Fairness: with all QUEUE_COUNT queues continuously eligible, grant order is 0,1,…,QUEUE_COUNT-1,0,… with no skips and no repeats.
- Width: index arithmetic wraps modulo QUEUE_COUNT. For non-power-of-two QUEUE_COUNT, indices ≥ QUEUE_COUNT are never produced.

Optional Feature:
- Macro: RR_SCHED_STATS_EN.
- When defined, add outputs:
  - stat_grant_count [31:0]: increments on each handshake, wraps at 2^32.
  - stat_idle_cycles [31:0]: increments each IDLE cycle with no eligible queue, wraps.
- Both counters reset to 0 on rst.
- When undefined, the ports and logic are absent and the rest of the behaviour is identical.

Test Plan:
- Post-reset, queue_req=8'hFF, queue_en=8'hFF, m_sel_ready=1, pkt_done 3 cycles after each handshake -> m_sel sequence 0,1,2,3,4,5,6,7,0.
- queue_req=8'b1000_0100, last_sel=2 -> next grant 7, then 2 (wrap).
- Only queue 5 eligible, last_sel=5 -> grant 5 again (sole-requester re-grant).
- OFFER with m_sel=3, m_sel_ready=0 for 5 cycles while queue_req[3] drops -> m_sel stays 3 with m_sel_valid held; handshake on cycle 6.
- Handshake and pkt_done in the same cycle -> busy never asserts; next m_sel_valid 2 cycles later if eligible.
- Assert rst during BUSY -> next cycle busy=0, m_sel_valid=0, last_sel=7; with RR_SCHED_STATS_EN defined, both counters read 0.

Source files
------------

// File: rtl/rr_queue_scheduler.sv
// Packet-granular round-robin scheduler: offers the next eligible queue after last_sel over
// valid/ready, then holds the grant until pkt_done. Optional counters under RR_SCHED_STATS_EN.
module rr_queue_scheduler #(
  parameter int unsigned QUEUE_COUNT = 8,
  parameter int unsigned SEL_WIDTH   = $clog2(QUEUE_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [QUEUE_COUNT-1:0] queue_req,
  input  logic [QUEUE_COUNT-1:0] queue_en,
  output logic [SEL_WIDTH-1:0]   m_sel,
  output logic                   m_sel_valid,
  input  logic                   m_sel_ready,
  input  logic                   pkt_done,
  output logic                   busy,
  output logic [SEL_WIDTH-1:0]   last_sel
`ifdef RR_SCHED_STATS_EN
  ,
  output logic [31:0]            stat_grant_count,
  output logic [31:0]            stat_idle_cycles
`endif
);

  typedef enum logic [1:0] {StIdle, StOffer, StBusy} state_e;

  state_e                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   m_sel_q, m_sel_d;
  logic [SEL_WIDTH-1:0]   last_sel_q, last_sel_d;
  logic                   m_sel_valid_q, m_sel_valid_d;
  logic                   busy_q, busy_d;
  logic [QUEUE_COUNT-1:0] eligible;
  logic                   found_hi, found_lo;
  logic [SEL_WIDTH-1:0]   hi_idx, lo_idx, next_sel;
  logic                   handshake;
  logic                   idle_empty;

  assign eligible = queue_req & queue_en;

  // Descending scan so the lowest matching index wins in each half of the circle.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = QUEUE_COUNT - 1; i >= 0; i--) begin
      if (eligible[i] && (SEL_WIDTH'(i) > last_sel_q)) begin
        found_hi = 1'b1;
        hi_idx   = SEL_WIDTH'(i);
      end
      if (eligible[i] && (SEL_WIDTH'(i) < last_sel_q)) begin
        found_lo = 1'b1;
        lo_idx   = SEL_WIDTH'(i);
      end
    end
    // Neither half hit while something is eligible: last_sel is the sole requester.
    next_sel = found_hi ? hi_idx : (found_lo ? lo_idx : last_sel_q);
  end

  always_comb begin
    state_d       = state_q;
    m_sel_d       = m_sel_q;
    m_sel_valid_d = m_sel_valid_q;
    busy_d        = busy_q;
    last_sel_d    = last_sel_q;
    handshake     = 1'b0;
    idle_empty    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|eligible) begin
          m_sel_d       = next_sel;
          m_sel_valid_d = 1'b1;
          state_d       = StOffer;
        end else begin
          idle_empty = 1'b1;
        end
      end
      StOffer: begin
        if (m_sel_valid_q && m_sel_ready) begin
          handshake     = 1'b1;
          last_sel_d    = m_sel_q;
          m_sel_valid_d = 1'b0;
          if (pkt_done) begin
            state_d = StIdle;
          end else begin
            busy_d  = 1'b1;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (pkt_done) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      m_sel_q       <= '0;
      m_sel_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      last_sel_q    <= SEL_WIDTH'(QUEUE_COUNT - 1);
    end else begin
      state_q       <= state_d;
      m_sel_q       <= m_sel_d;
      m_sel_valid_q <= m_sel_valid_d;
      busy_q        <= busy_d;
      last_sel_q    <= last_sel_d;
    end
  end

  assign m_sel       = m_sel_q;
  assign m_sel_valid = m_sel_valid_q;
  assign busy        = busy_q;
  assign last_sel    = last_sel_q;

`ifdef RR_SCHED_STATS_EN
  logic [31:0] grant_cnt_q, idle_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      if (handshake) grant_cnt_q <= grant_cnt_q + 32'd1;
      if (idle_empty) idle_cnt_q <= idle_cnt_q + 32'd1;
    end
  end

  assign stat_grant_count = grant_cnt_q;
  assign stat_idle_cycles = idle_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = handshake ^ idle_empty;
`endif

endmodule
